// File: rtl/ysyx_exu_gpr_core.sv
// Execute-stage core: reset retiming flop, 32-entry GPR file, operand select and ALU.
// Latency: reads and ALU outputs are combinational; register writes land on the next rising edge.
// Backpressure: none; every input is consumed each cycle and outputs are always valid.
//
// Ports:
//   clk, rstn          - clock and synchronous active-high reset request
//   rstn_sync          - rstn delayed one edge; clears the register file and other CPU units
//   wr_en_Rd, addr_Rd, data_Rd        - register write port
//   addr_Rs1/2, data_Rs1/2            - asynchronous read ports (x0 always reads 0)
//   pc, imm, exu_opt_code, exu_sel_code - operand sources and ALU controls
//   exu_res, zero                     - ALU result and result-is-zero flag
module ysyx_exu_gpr_core #(
  parameter int CPU_WIDTH     = 32,
  parameter int EXU_OPT_WIDTH = 4,
  parameter int EXU_SEL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     rstn_sync,
  input  logic                     wr_en_Rd,
  input  logic [4:0]               addr_Rd,
  input  logic [CPU_WIDTH-1:0]     data_Rd,
  input  logic [4:0]               addr_Rs1,
  input  logic [4:0]               addr_Rs2,
  output logic [CPU_WIDTH-1:0]     data_Rs1,
  output logic [CPU_WIDTH-1:0]     data_Rs2,
  input  logic [CPU_WIDTH-1:0]     pc,
  input  logic [CPU_WIDTH-1:0]     imm,
  input  logic [EXU_OPT_WIDTH-1:0] exu_opt_code,
  input  logic [EXU_SEL_WIDTH-1:0] exu_sel_code,
  output logic [CPU_WIDTH-1:0]     exu_res,
  output logic                     zero
);

  localparam int NUM_REGS = 32;

  // Operand-select encodings
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_RS1_RS2 = EXU_SEL_WIDTH'(0);
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_RS1_IMM = EXU_SEL_WIDTH'(1);
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_PC_IMM  = EXU_SEL_WIDTH'(2);
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_PC_4    = EXU_SEL_WIDTH'(3);
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_0_IMM   = EXU_SEL_WIDTH'(4);

  // ALU opcode encodings
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_ADD  = EXU_OPT_WIDTH'(0);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SUB  = EXU_OPT_WIDTH'(1);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SLL  = EXU_OPT_WIDTH'(2);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SLT  = EXU_OPT_WIDTH'(3);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SLTU = EXU_OPT_WIDTH'(4);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_XOR  = EXU_OPT_WIDTH'(5);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SRL  = EXU_OPT_WIDTH'(6);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SRA  = EXU_OPT_WIDTH'(7);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_OR   = EXU_OPT_WIDTH'(8);
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_AND  = EXU_OPT_WIDTH'(9);

  localparam logic [CPU_WIDTH-1:0] LINK_OFFSET = CPU_WIDTH'(4);

  // ---------------------------------------------------------------------------
  // Reset retiming: a plain one-edge delay, no other logic on this path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    rstn_sync <= rstn;
  end

  // ---------------------------------------------------------------------------
  // Register file. The clear is driven by the retimed reset, so a write issued
  // in the first cycle of rstn still completes and is wiped one edge later.
  // Entry 0 is cleared but never written; reads of x0 are forced to 0 anyway.
  // ---------------------------------------------------------------------------
  logic [CPU_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rstn_sync) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_Rd && (addr_Rd != 5'd0)) begin
      regs[addr_Rd] <= data_Rd;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the pre-edge value.
  assign data_Rs1 = (addr_Rs1 == 5'd0) ? '0 : regs[addr_Rs1];
  assign data_Rs2 = (addr_Rs2 == 5'd0) ? '0 : regs[addr_Rs2];

  // ---------------------------------------------------------------------------
  // Operand select
  // ---------------------------------------------------------------------------
  logic [CPU_WIDTH-1:0] opd_a;
  logic [CPU_WIDTH-1:0] opd_b;

  always_comb begin
    opd_a = '0;
    opd_b = '0;
    case (exu_sel_code)
      SEL_RS1_RS2: begin opd_a = data_Rs1; opd_b = data_Rs2;    end
      SEL_RS1_IMM: begin opd_a = data_Rs1; opd_b = imm;         end
      SEL_PC_IMM:  begin opd_a = pc;       opd_b = imm;         end
      SEL_PC_4:    begin opd_a = pc;       opd_b = LINK_OFFSET; end
      SEL_0_IMM:   begin opd_a = '0;       opd_b = imm;         end
      default:     begin opd_a = '0;       opd_b = '0;          end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU. Shift amount is always the low five bits of B (RV32I semantics).
  // ---------------------------------------------------------------------------
  logic [4:0]                  shamt;
  logic signed [CPU_WIDTH-1:0] opd_a_s;
  logic signed [CPU_WIDTH-1:0] opd_b_s;

  assign shamt   = opd_b[4:0];
  assign opd_a_s = opd_a;
  assign opd_b_s = opd_b;

  always_comb begin
    exu_res = '0;
    case (exu_opt_code)
      OPT_ADD:  exu_res = opd_a + opd_b;
      OPT_SUB:  exu_res = opd_a - opd_b;
      OPT_SLL:  exu_res = opd_a << shamt;
      OPT_SLT:  exu_res = CPU_WIDTH'(opd_a_s < opd_b_s);
      OPT_SLTU: exu_res = CPU_WIDTH'(opd_a < opd_b);
      OPT_XOR:  exu_res = opd_a ^ opd_b;
      OPT_SRL:  exu_res = opd_a >> shamt;
      OPT_SRA:  exu_res = opd_a_s >>> shamt;
      OPT_OR:   exu_res = opd_a | opd_b;
      OPT_AND:  exu_res = opd_a & opd_b;
      default:  exu_res = '0;
    endcase
  end

  // Branch decisions in the PCU key off this flag.
  assign zero = (exu_res == '0);

endmodule

// File: tb/tb_ysyx_exu_gpr_core.sv
module tb_ysyx_exu_gpr_core;

  logic        clk;
  logic        rstn;
  logic        rstn_sync;
  logic        wr_en_Rd;
  logic [4:0]  addr_Rd;
  logic [31:0] data_Rd;
  logic [4:0]  addr_Rs1;
  logic [4:0]  addr_Rs2;
  logic [31:0] data_Rs1;
  logic [31:0] data_Rs2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [3:0]  exu_opt_code;
  logic [2:0]  exu_sel_code;
  logic [31:0] exu_res;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_sync;

  ysyx_exu_gpr_core dut (
    .clk          (clk),
    .rstn         (rstn),
    .rstn_sync    (rstn_sync),
    .wr_en_Rd     (wr_en_Rd),
    .addr_Rd      (addr_Rd),
    .data_Rd      (data_Rd),
    .addr_Rs1     (addr_Rs1),
    .addr_Rs2     (addr_Rs2),
    .data_Rs1     (data_Rs1),
    .data_Rs2     (data_Rs2),
    .pc           (pc),
    .imm          (imm),
    .exu_opt_code (exu_opt_code),
    .exu_sel_code (exu_sel_code),
    .exu_res      (exu_res),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; model applies the rules using inputs held stable across it.
  task automatic tick();
    @(posedge clk);
    if (m_sync) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (wr_en_Rd && addr_Rd != 5'd0) begin
      m_regs[addr_Rd] = data_Rd;
    end
    m_sync = rstn;
    #1;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  function automatic logic [31:0] m_exec(input logic [2:0] sel, input logic [3:0] op,
                                         input logic [31:0] r1, input logic [31:0] r2,
                                         input logic [31:0] p, input logic [31:0] im);
    logic [31:0] a, b, fill;
    int sh;
    a = 0; b = 0;
    if (sel == 0)      begin a = r1; b = r2; end
    else if (sel == 1) begin a = r1; b = im; end
    else if (sel == 2) begin a = p;  b = im; end
    else if (sel == 3) begin a = p;  b = 4;  end
    else if (sel == 4) begin a = 0;  b = im; end
    sh = int'(b % 32);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | fill;
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en_Rd = 1'b1; addr_Rd = a; data_Rd = d;
    tick();
    @(negedge clk);
    wr_en_Rd = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    n_tests++;
    if (rstn_sync !== 1'b1) begin
      n_fail++; $display("FAIL reset_sync_rise: got %b expected 1", rstn_sync);
    end
    tick();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_tests++;
    if (rstn_sync !== 1'b1) begin
      n_fail++; $display("FAIL reset_sync_lag: got %b expected 1", rstn_sync);
    end
    tick();
    n_tests++;
    if (rstn_sync !== 1'b0) begin
      n_fail++; $display("FAIL reset_sync_fall: got %b expected 0", rstn_sync);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      addr_Rs1 = 5'(i); addr_Rs2 = 5'(31 - i);
      #1;
      n_tests++;
      if (data_Rs1 !== 32'd0 || data_Rs2 !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg_clear x%0d: got %h/%h expected 0", i, data_Rs1, data_Rs2);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_en_Rd = 1'b1; addr_Rd = 5'd5; data_Rd = 32'hDEAD_BEEF; addr_Rs1 = 5'd5;
    #1;
    n_tests++;
    if (data_Rs1 !== 32'd0) begin
      n_fail++; $display("FAIL same_cycle_read: got %h expected 00000000", data_Rs1);
    end
    tick();
    write_reg(5'd0, 32'h0000_1234);
    addr_Rs1 = 5'd5; addr_Rs2 = 5'd0;
    #1;
    n_tests++;
    if (data_Rs1 !== 32'hDEAD_BEEF || data_Rs2 !== 32'd0) begin
      n_fail++; $display("FAIL write_read: got %h/%h expected deadbeef/00000000", data_Rs1, data_Rs2);
    end
  endtask

  task automatic test_alu_reg();
    logic [3:0]  ops  [4] = '{4'd0, 4'd3, 4'd4, 4'd1};
    logic [31:0] exps [4] = '{32'h0, 32'h1, 32'h0, 32'hFFFF_FFFE};
    write_reg(5'd1, 32'hFFFF_FFFF);
    write_reg(5'd2, 32'h0000_0001);
    addr_Rs1 = 5'd1; addr_Rs2 = 5'd2; exu_sel_code = 3'd0;
    for (int i = 0; i < 4; i++) begin
      exu_opt_code = ops[i];
      #1;
      n_tests++;
      if (exu_res !== exps[i] || zero !== (exps[i] == 32'd0)) begin
        n_fail++; $display("FAIL alu_reg op%0d: got %h z=%b expected %h", ops[i], exu_res, zero, exps[i]);
      end
    end
  endtask

  task automatic test_alu_shift();
    logic [3:0]  ops  [3] = '{4'd7, 4'd6, 4'd2};
    logic [31:0] exps [3] = '{32'hF800_0000, 32'h0800_0000, 32'h0};
    write_reg(5'd1, 32'h8000_0000);
    addr_Rs1 = 5'd1; imm = 32'd4; exu_sel_code = 3'd1;
    for (int i = 0; i < 3; i++) begin
      exu_opt_code = ops[i];
      #1;
      n_tests++;
      if (exu_res !== exps[i]) begin
        n_fail++; $display("FAIL alu_shift op%0d: got %h expected %h", ops[i], exu_res, exps[i]);
      end
    end
  endtask

  task automatic test_pc_ops();
    logic [2:0]  sels [3] = '{3'd2, 3'd3, 3'd4};
    logic [31:0] exps [3] = '{32'h8000_0000, 32'h8000_0014, 32'hFFFF_FFF0};
    @(negedge clk);
    pc = 32'h8000_0010; imm = 32'hFFFF_FFF0; exu_opt_code = 4'd0;
    for (int i = 0; i < 3; i++) begin
      exu_sel_code = sels[i];
      #1;
      n_tests++;
      if (exu_res !== exps[i]) begin
        n_fail++; $display("FAIL pc_ops sel%0d: got %h expected %h", sels[i], exu_res, exps[i]);
      end
    end
  endtask

  task automatic test_reset_write_block();
    // Write issued in the first reset cycle completes, then gets cleared.
    @(negedge clk);
    rstn = 1'b1; wr_en_Rd = 1'b1; addr_Rd = 5'd4; data_Rd = 32'd9;
    tick();
    @(negedge clk);
    rstn = 1'b0; addr_Rs1 = 5'd4; addr_Rd = 5'd3; data_Rd = 32'd7;
    #1;
    n_tests++;
    if (data_Rs1 !== 32'd9) begin
      n_fail++; $display("FAIL reset_midop_write: got %h expected 00000009", data_Rs1);
    end
    tick();
    @(negedge clk);
    wr_en_Rd = 1'b0; addr_Rs1 = 5'd3; addr_Rs2 = 5'd4;
    #1;
    n_tests++;
    if (data_Rs1 !== 32'd0 || data_Rs2 !== 32'd0) begin
      n_fail++; $display("FAIL reset_write_block: got %h/%h expected 0/0", data_Rs1, data_Rs2);
    end
    exu_sel_code = 3'd0; exu_opt_code = 4'd12;
    #1;
    n_tests++;
    if (exu_res !== 32'd0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL undefined_op: got %h z=%b expected 0 z=1", exu_res, zero);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_r1, exp_r2, exp_res;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      rstn         = ($urandom_range(0, 39) == 0);
      wr_en_Rd     = $urandom_range(0, 1) == 1;
      addr_Rd      = 5'($urandom_range(0, 31));
      data_Rd      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      addr_Rs1     = 5'($urandom_range(0, 31));
      addr_Rs2     = 5'($urandom_range(0, 31));
      pc           = $urandom;
      imm          = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exu_opt_code = 4'($urandom_range(0, 15));
      exu_sel_code = 3'($urandom_range(0, 7));
      #1;
      exp_r1  = m_read(addr_Rs1);
      exp_r2  = m_read(addr_Rs2);
      exp_res = m_exec(exu_sel_code, exu_opt_code, exp_r1, exp_r2, pc, imm);
      n_tests++;
      if (data_Rs1 !== exp_r1 || data_Rs2 !== exp_r2) begin
        n_fail++; $display("FAIL rand_read it%0d: got %h/%h expected %h/%h", it, data_Rs1, data_Rs2, exp_r1, exp_r2);
      end
      n_tests++;
      if (exu_res !== exp_res || zero !== (exp_res == 32'd0)) begin
        n_fail++; $display("FAIL rand_alu it%0d sel%0d op%0d: got %h z=%b expected %h",
                           it, exu_sel_code, exu_opt_code, exu_res, zero, exp_res);
      end
      n_tests++;
      if (rstn_sync !== m_sync) begin
        n_fail++; $display("FAIL rand_sync it%0d: got %b expected %b", it, rstn_sync, m_sync);
      end
      tick();
    end
  endtask

  initial begin
    rstn = 1'b1; wr_en_Rd = 1'b0; addr_Rd = '0; data_Rd = '0;
    addr_Rs1 = '0; addr_Rs2 = '0; pc = '0; imm = '0;
    exu_opt_code = '0; exu_sel_code = '0;
    m_sync = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    test_reset();
    test_write_read();
    test_alu_reg();
    test_alu_shift();
    test_pc_ops();
    test_reset_write_block();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
